// File: rtl/fp_pkg.sv
// Shared constants, bit positions and types for the FP normalize/round/pack path.
package fp_pkg;

    // Default widths: 28-bit mantissa (carry, hidden, 23 fraction, G, R, S)
    // and a 10-bit signed biased exponent.
    localparam int DEF_MANT_W = 28;
    localparam int DEF_EXP_W  = 10;

    localparam int          BIAS    = 127;
    localparam int          EXP_MAX = 255;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;

    // Bit positions inside the raw mantissa coming from the adder.
    localparam int CARRY_BIT  = 27;
    localparam int HIDDEN_BIT = 26;
    localparam int FRAC_LSB   = 3;
    localparam int G_BIT      = 2;
    localparam int R_BIT      = 1;
    localparam int S_BIT      = 0;

    // Positions inside out_flags = {invalid, overflow, underflow, inexact}.
    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/fp_rne_round.sv
// Round-to-nearest-even on a significand with guard/round/sticky bits.
// Purely combinational; carry reports that the significand overflowed its width.
module fp_rne_round #(
    parameter int SIG_W = 24
) (
    input  logic [SIG_W-1:0] sig,
    input  logic             guard,
    input  logic             round_bit,
    input  logic             sticky,
    output logic [SIG_W-1:0] rounded,
    output logic             carry,
    output logic             inexact
);

    logic round_up;

    // Increment when above half, or exactly half with an odd LSB.
    always_comb begin
        round_up         = guard & (round_bit | sticky | sig[0]);
        {carry, rounded} = {1'b0, sig} + {{SIG_W{1'b0}}, round_up};
        inexact          = guard | round_bit | sticky;
    end

endmodule

// File: rtl/fp_norm_round.sv
// Post-add normalize / round / pack stage for binary32.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; in_ready is high only in IDLE, out_valid only in DONE, and the
// output payload is held stable until out_ready accepts it.
module fp_norm_round
    import fp_pkg::*;
#(
    parameter int MANT_W = DEF_MANT_W,
    parameter int EXP_W  = DEF_EXP_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W-1:0] in_mant,
    input  logic              in_zero,
    input  logic              in_inf,
    input  logic              in_nan,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_result,
    output logic [3:0]        out_flags,
    output state_t            dbg_state
);

    localparam logic signed [EXP_W-1:0] EXP_ONE   = EXP_W'(1);
    localparam logic signed [EXP_W-1:0] EXP_MAX_S = EXP_W'(EXP_MAX);

    state_t                   state;
    state_t                   state_next;
    logic                     sign_q;
    logic signed [EXP_W-1:0]  exp_q;
    logic [MANT_W-1:0]        mant_q;

    logic                     accept;
    logic                     norm_rshift;
    logic                     norm_lshift;
    logic [MANT_W-1:0]        mant_rsh;
    logic [MANT_W-1:0]        mant_lsh;

    logic [23:0]              rnd_sig;
    logic                     rnd_carry;
    logic                     rnd_inexact;
    logic [23:0]              m24;
    logic signed [EXP_W-1:0]  exp_rnd;
    logic [31:0]              pack_result;
    logic [3:0]               pack_flags;

    assign accept    = in_valid & in_ready;
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign dbg_state = state;

    // Pick this cycle's normalization step; right shifts (carry or
    // denormalization) outrank left shifts, and the sticky bit only ever
    // accumulates: right shifts OR the dropped bit into it, left shifts keep it.
    always_comb begin
        norm_rshift = mant_q[CARRY_BIT] | (exp_q < EXP_ONE);
        norm_lshift = ~norm_rshift & ~mant_q[HIDDEN_BIT] & (exp_q > EXP_ONE);
        mant_rsh    = {1'b0, mant_q[MANT_W-1:2], mant_q[R_BIT] | mant_q[S_BIT]};
        mant_lsh    = {mant_q[MANT_W-2:0], mant_q[S_BIT]};
    end

    fp_rne_round #(
        .SIG_W (24)
    ) u_rne (
        .sig       (mant_q[HIDDEN_BIT:FRAC_LSB]),
        .guard     (mant_q[G_BIT]),
        .round_bit (mant_q[R_BIT]),
        .sticky    (mant_q[S_BIT]),
        .rounded   (rnd_sig),
        .carry     (rnd_carry),
        .inexact   (rnd_inexact)
    );

    // Fold a rounding carry back to 1.0 and pack the binary32 word and flags.
    always_comb begin
        m24         = rnd_carry ? 24'h80_0000 : rnd_sig;
        exp_rnd     = exp_q + $signed({{(EXP_W-1){1'b0}}, rnd_carry});
        pack_result = '0;
        pack_flags  = '0;
        if (exp_rnd >= EXP_MAX_S) begin
            pack_result                = {sign_q, 8'hFF, 23'h0};
            pack_flags[FLAG_OVERFLOW]  = 1'b1;
            pack_flags[FLAG_INEXACT]   = 1'b1;
        end else if (!m24[23]) begin
            // Hidden bit still clear: only reachable at exp==1, so subnormal.
            pack_result                = {sign_q, 8'h00, m24[22:0]};
            pack_flags[FLAG_UNDERFLOW] = rnd_inexact;
            pack_flags[FLAG_INEXACT]   = rnd_inexact;
        end else begin
            // Also covers a subnormal rounding up into the smallest normal,
            // where exp is 1 and the exponent field becomes 1.
            pack_result                = {sign_q, exp_rnd[7:0], m24[22:0]};
            pack_flags[FLAG_INEXACT]   = rnd_inexact;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic: specials skip straight to DONE, normals walk NORM/ROUND.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (in_nan | in_inf | in_zero | (in_mant == '0)) state_next = DONE;
                    else                                             state_next = NORM;
                end
            end
            NORM: begin
                if (!norm_rshift && !norm_lshift) state_next = ROUND;
            end
            ROUND: state_next = DONE;
            DONE: begin
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: capture, shift one step per NORM cycle, load the packed result.
    always_ff @(posedge clk) begin
        if (reset) begin
            sign_q     <= 1'b0;
            exp_q      <= '0;
            mant_q     <= '0;
            out_result <= '0;
            out_flags  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sign_q <= in_sign;
                        exp_q  <= $signed(in_exp);
                        mant_q <= in_mant;
                        if (in_nan) begin
                            out_result <= QNAN;
                            out_flags  <= 4'(1 << FLAG_INVALID);
                        end else if (in_inf) begin
                            out_result <= {in_sign, 8'hFF, 23'h0};
                            out_flags  <= '0;
                        end else if (in_zero || (in_mant == '0)) begin
                            out_result <= {in_sign, 31'h0};
                            out_flags  <= '0;
                        end
                    end
                end
                NORM: begin
                    if (norm_rshift) begin
                        mant_q <= mant_rsh;
                        exp_q  <= exp_q + EXP_ONE;
                    end else if (norm_lshift) begin
                        mant_q <= mant_lsh;
                        exp_q  <= exp_q - EXP_ONE;
                    end
                end
                ROUND: begin
                    out_result <= pack_result;
                    out_flags  <= pack_flags;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_norm_round.sv
// Self-checking bench for fp_norm_round: directed cases plus random operations
// compared against an arithmetic reference model.
module tb_fp_norm_round;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic              in_sign;
    logic [9:0]        in_exp;
    logic [27:0]       in_mant;
    logic              in_zero;
    logic              in_inf;
    logic              in_nan;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_result;
    logic [3:0]        out_flags;
    fp_pkg::state_t    dbg_state;

    int checks = 0;
    int errors = 0;

    fp_norm_round dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_mant    (in_mant),
        .in_zero    (in_zero),
        .in_inf     (in_inf),
        .in_nan     (in_nan),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags),
        .dbg_state  (dbg_state)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got=%h expected=%h", tag, got, want);
        end
    endtask

    // Reference: value-level walk of the normalization rules on an integer
    // mantissa, then round-half-even and IEEE packing. lat counts edges after
    // the accept edge until out_valid is seen.
    function automatic void ref_model(input bit sg, input int e_in, input logic [27:0] m_in,
                                      input bit z, input bit inf, input bit nan,
                                      output logic [31:0] res, output logic [3:0] fl,
                                      output int lat);
        longint mv;
        longint sig;
        int     e;
        int     grs;
        int     guard_cnt;
        bit     up;
        bit     inx;
        mv  = longint'(m_in);
        e   = e_in;
        fl  = 4'b0000;
        res = 32'h0;
        lat = 0;
        if (nan) begin
            res = 32'h7FC0_0000;
            fl  = 4'b1000;
        end else if (inf) begin
            res = {sg, 8'hFF, 23'h0};
        end else if (z || m_in == 28'h0) begin
            res = {sg, 31'h0};
        end else begin
            lat       = 2;
            guard_cnt = 0;
            while (guard_cnt < 100) begin
                guard_cnt++;
                if (mv >= (64'sd1 << 27) || e < 1) begin
                    mv = (mv / 2) | (mv % 2);
                    e++;
                    lat++;
                end else if (mv < (64'sd1 << 26) && e > 1) begin
                    mv = mv * 2 + (mv % 2);
                    e--;
                    lat++;
                end else begin
                    break;
                end
            end
            grs = int'(mv % 8);
            sig = mv / 8;
            inx = (grs != 0);
            up  = (grs >= 4) && ((grs % 4) != 0 || (sig % 2) == 1);
            sig = sig + longint'(up);
            if (sig >= (64'sd1 << 24)) begin
                sig = sig / 2;
                e++;
            end
            if (e >= 255) begin
                res = {sg, 8'hFF, 23'h0};
                fl  = 4'b0101;
            end else if (sig < (64'sd1 << 23)) begin
                res = {sg, 8'h00, sig[22:0]};
                fl  = {2'b00, inx, inx};
            end else begin
                res = {sg, e[7:0], sig[22:0]};
                fl  = {3'b000, inx};
            end
        end
    endfunction

    // Present one operation and wait for the accept edge.
    task automatic drive_op(input bit sg, input int e, input logic [27:0] m,
                            input bit z, input bit inf, input bit nan, input string tag);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        check({tag, "/in_ready_idle"}, {31'h0, in_ready}, 32'h1);
        in_sign  = sg;
        in_exp   = e[9:0];
        in_mant  = m;
        in_zero  = z;
        in_inf   = inf;
        in_nan   = nan;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Full operation: accept, latency, payload, optional backpressure, drain.
    task automatic run_op(input bit sg, input int e, input logic [27:0] m,
                          input bit z, input bit inf, input bit nan, input int hold,
                          input bit has_want, input logic [31:0] want, input string tag);
        logic [31:0] exp_res;
        logic [3:0]  exp_fl;
        int          exp_lat;
        int          lat;
        ref_model(sg, e, m, z, inf, nan, exp_res, exp_fl, exp_lat);
        drive_op(sg, e, m, z, inf, nan, tag);
        lat = 0;
        while (!out_valid && lat < 80) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "/latency"}, lat, exp_lat);
        check({tag, "/result"}, out_result, exp_res);
        check({tag, "/flags"}, {28'h0, out_flags}, {28'h0, exp_fl});
        if (has_want) check({tag, "/spec_value"}, out_result, want);
        check({tag, "/in_ready_busy"}, {31'h0, in_ready}, 32'h0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "/hold_valid"}, {31'h0, out_valid}, 32'h1);
            check({tag, "/hold_result"}, out_result, exp_res);
            check({tag, "/hold_in_ready"}, {31'h0, in_ready}, 32'h0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "/drained_valid"}, {31'h0, out_valid}, 32'h0);
        check({tag, "/drained_ready"}, {31'h0, in_ready}, 32'h1);
    endtask

    initial begin
        int          e;
        int          sh;
        int          sel;
        logic [27:0] m;
        bit          sg;

        // Reset.
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_mant   = '0;
        in_zero   = 1'b0;
        in_inf    = 1'b0;
        in_nan    = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset/in_ready", {31'h0, in_ready}, 32'h1);
        check("reset/out_valid", {31'h0, out_valid}, 32'h0);
        check("reset/out_result", out_result, 32'h0);
        check("reset/out_flags", {28'h0, out_flags}, 32'h0);

        // Directed cases.
        run_op(0, 127, 28'h1 << 26, 0, 0, 0, 0, 1, 32'h3F80_0000, "one");
        run_op(0, 127, 28'h1 << 20, 0, 0, 0, 0, 1, 32'h3C80_0000, "cancel6");
        run_op(0, 127, {1'b0, 1'b1, 23'h7F_FFFF, 3'b100}, 0, 0, 0, 0, 1, 32'h4000_0000, "tie_carry");
        run_op(0, 127, {1'b0, 1'b1, 23'h0, 3'b100}, 0, 0, 0, 0, 1, 32'h3F80_0000, "tie_even");
        run_op(0, 254, 28'h1 << 27, 0, 0, 0, 0, 1, 32'h7F80_0000, "overflow");
        run_op(0, 0, 28'h1 << 26, 0, 0, 0, 0, 1, 32'h0040_0000, "subnormal");
        run_op(0, 127, 28'h1 << 26, 0, 0, 1, 0, 1, 32'h7FC0_0000, "nan");
        run_op(1, 127, 28'h1 << 26, 1, 0, 0, 0, 1, 32'h8000_0000, "zero_neg");
        run_op(0, 127, 28'h0, 0, 0, 0, 0, 1, 32'h0000_0000, "zero_mant");
        run_op(1, 127, 28'h1 << 26, 0, 1, 1, 0, 1, 32'h7FC0_0000, "nan_inf");
        run_op(1, 10, 28'h1 << 26, 0, 1, 0, 0, 1, 32'hFF80_0000, "inf_neg");
        run_op(0, 1, {2'b00, 23'h7F_FFFF, 3'b110}, 0, 0, 0, 0, 1, 32'h0080_0000, "sub_to_norm");
        run_op(0, 130, 28'h0AB_CDEF, 0, 0, 0, 5, 0, 32'h0, "backpressure");

        // Reset in the middle of a long normalization.
        drive_op(0, 127, 28'h4, 0, 0, 0, "reset_mid");
        repeat (3) @(posedge clk);
        #1;
        check("reset_mid/state_busy", {31'h0, in_ready}, 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("reset_mid/out_valid", {31'h0, out_valid}, 32'h0);
        check("reset_mid/in_ready", {31'h0, in_ready}, 32'h1);
        run_op(0, 127, 28'h1 << 26, 0, 0, 0, 0, 1, 32'h3F80_0000, "after_reset");

        // Random operations across the full exponent range and shift depths.
        for (int k = 0; k < 60; k++) begin
            sg  = 1'($urandom_range(0, 1));
            e   = int'($urandom_range(0, 328)) - 28;
            sh  = int'($urandom_range(0, 27));
            m   = 28'($urandom()) >> sh;
            sel = int'($urandom_range(0, 15));
            run_op(sg, e, m, sel == 2, sel == 1 || sel == 3, sel == 0 || sel == 3,
                   int'($urandom_range(0, 2)), 0, 32'h0, $sformatf("rand%0d", k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
